// File: rtl/conv2d_seq_acc.sv
// conv2d_seq_acc
// Time-multiplexed convolution datapath. A kernel window arrives as NUM_BEATS
// beats of LANES samples. Every beat is multiplied by per-channel weights and
// summed at full precision for NUM_CH channels in parallel. After the last
// beat, bias is added and the selected activation (none / ReLU / hard-swish /
// ReLU6) is applied. The result is saturated and held on a valid/ready output.
`timescale 1ns/1ps

module conv2d_seq_acc #(
    parameter int bitsize   = 18,
    parameter int FRAC_BITS = 9,
    parameter int LANES     = 9,
    parameter int NUM_BEATS = 3,
    parameter int NUM_CH    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [1:0]                        act_mode,
    input  logic [bitsize*NUM_CH-1:0]         bias,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [bitsize*LANES-1:0]          data_in,
    input  logic [bitsize*LANES*NUM_CH-1:0]   weights,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [bitsize*NUM_CH-1:0]         out_data
);

    // The accumulator is wide enough that a whole window of worst-case
    // products cannot overflow.
    localparam int ACC_W = 2*bitsize + $clog2(LANES*NUM_BEATS) + 1;
    // The activation stage needs headroom for y*t*INV6 before the shifts.
    localparam int EXT_W = ACC_W + 2*bitsize;
    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    // INV6 is 1/6 in Q format, rounded to nearest.
    localparam int INV6  = ((1 << FRAC_BITS) + 3) / 6;

    localparam logic signed [EXT_W-1:0] THREE_Q = EXT_W'(3 << FRAC_BITS);
    localparam logic signed [EXT_W-1:0] SIX_Q   = EXT_W'(6 << FRAC_BITS);
    localparam logic signed [EXT_W-1:0] INV6_Q  = EXT_W'(INV6);
    localparam logic signed [EXT_W-1:0] MAX_Q   = EXT_W'((1 << (bitsize-1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_Q   = ~MAX_Q;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_FIN,
        ST_HOLD
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          beat_cnt;
    logic signed [ACC_W-1:0]   acc      [NUM_CH];
    logic signed [ACC_W-1:0]   beat_sum [NUM_CH];
    logic [bitsize*NUM_CH-1:0] bias_reg;
    logic [1:0]                act_mode_reg;
    logic [bitsize*NUM_CH-1:0] fin_result;
    logic                      accept;
    logic                      first_beat;
    logic                      last_beat;

    // A beat offered together with flush is dropped.
    assign accept     = in_valid && in_ready && !flush;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == CNT_W'(NUM_BEATS - 1));

    // Bias, rounding shift, activation and saturation for one channel.
    // Shifts are arithmetic, so every rescale rounds toward minus infinity.
    function automatic logic signed [bitsize-1:0] finish_channel(
        input logic signed [ACC_W-1:0]   a,
        input logic signed [bitsize-1:0] b,
        input logic [1:0]                mode
    );
        logic signed [EXT_W-1:0] y;
        logic signed [EXT_W-1:0] t;
        logic signed [EXT_W-1:0] h;
        logic signed [EXT_W-1:0] r;
        y = (EXT_W'(a) + (EXT_W'(b) <<< FRAC_BITS)) >>> FRAC_BITS;
        t = '0;
        h = '0;
        case (mode)
            2'd1: r = y[EXT_W-1] ? '0 : y;
            2'd2: begin
                t = y + THREE_Q;
                if (t[EXT_W-1]) begin
                    t = '0;
                end else if (t > SIX_Q) begin
                    t = SIX_Q;
                end
                h = (y * t) >>> FRAC_BITS;
                r = (h * INV6_Q) >>> FRAC_BITS;
            end
            2'd3: r = y[EXT_W-1] ? '0 : ((y > SIX_Q) ? SIX_Q : y);
            default: r = y;
        endcase
        if (r > MAX_Q) begin
            r = MAX_Q;
        end else if (r < MIN_Q) begin
            r = MIN_Q;
        end
        return r[bitsize-1:0];
    endfunction

    // Per-channel dot product of the current beat with its weights.
    always_comb begin : beat_mac
        logic signed [2*bitsize-1:0] d_ext;
        logic signed [2*bitsize-1:0] w_ext;
        logic signed [2*bitsize-1:0] prod;
        d_ext = '0;
        w_ext = '0;
        prod  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            beat_sum[c] = '0;
            for (int l = 0; l < LANES; l++) begin
                d_ext = (2*bitsize)'($signed(data_in[l*bitsize +: bitsize]));
                w_ext = (2*bitsize)'($signed(weights[(c*LANES+l)*bitsize +: bitsize]));
                prod  = d_ext * w_ext;
                beat_sum[c] = beat_sum[c] + ACC_W'(prod);
            end
        end
    end

    // Finished, activated and saturated value for every channel.
    always_comb begin
        fin_result = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            fin_result[c*bitsize +: bitsize] =
                finish_channel(acc[c], $signed(bias_reg[c*bitsize +: bitsize]), act_mode_reg);
        end
    end

    // Accumulate accepted beats and capture window settings on the first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
            end
            bias_reg     <= '0;
            act_mode_reg <= '0;
        end else if (accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= first_beat ? beat_sum[c] : acc[c] + beat_sum[c];
            end
            if (first_beat) begin
                bias_reg     <= bias;
                act_mode_reg <= act_mode;
            end
        end
    end

    // Window sequencing with registered handshake outputs and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACC;
            beat_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            state     <= ST_ACC;
            beat_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= ST_FIN;
                            in_ready <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FIN: begin
                    out_data  <= fin_result;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_ACC;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_ACC;
                    beat_cnt  <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_seq_acc.sv
// Directed self-checking bench for conv2d_seq_acc: arithmetic, activations,
// saturation, handshake/backpressure, flush and asynchronous reset.
`timescale 1ns/1ps

module tb_conv2d_seq_acc;

    localparam int W         = 18;
    localparam int F         = 9;
    localparam int LANES     = 9;
    localparam int NUM_BEATS = 3;
    localparam int NUM_CH    = 16;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          flush;
    logic [1:0]                    act_mode;
    logic [W*NUM_CH-1:0]           bias;
    logic                          in_valid;
    logic                          in_ready;
    logic [W*LANES-1:0]            data_in;
    logic [W*LANES*NUM_CH-1:0]     weights;
    logic                          out_valid;
    logic                          out_ready;
    logic [W*NUM_CH-1:0]           out_data;

    int assert_count = 0;
    int fail_count   = 0;

    logic [W*LANES-1:0]        beat_data    [NUM_BEATS];
    logic [W*LANES*NUM_CH-1:0] beat_weights [NUM_BEATS];
    logic signed [W-1:0]       expected     [NUM_CH];

    conv2d_seq_acc #(
        .bitsize  (W),
        .FRAC_BITS(F),
        .LANES    (LANES),
        .NUM_BEATS(NUM_BEATS),
        .NUM_CH   (NUM_CH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .act_mode (act_mode),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .weights  (weights),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] required);
        assert_count++;
        assert (observed === required) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d required=%0d", tag, observed, required);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            checkValue($sformatf("%s_ch%0d", tag, c), $signed(out_data[c*W +: W]), expected[c]);
        end
    endtask

    task automatic setUniform(input int d, input int w);
        for (int b = 0; b < NUM_BEATS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                beat_data[b][l*W +: W] = W'(d);
            end
            for (int k = 0; k < LANES*NUM_CH; k++) begin
                beat_weights[b][k*W +: W] = W'(w);
            end
        end
    endtask

    task automatic setBias(input int v);
        for (int c = 0; c < NUM_CH; c++) begin
            bias[c*W +: W] = W'(v);
        end
    endtask

    task automatic setExpected(input int v);
        for (int c = 0; c < NUM_CH; c++) begin
            expected[c] = W'(v);
        end
    endtask

    task automatic applyStimulus(input int gap, input bit scramble);
        for (int b = 0; b < NUM_BEATS; b++) begin
            data_in  = beat_data[b];
            weights  = beat_weights[b];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (scramble && b == 0) begin
                bias     = ~bias;
                act_mode = 2'd1;
            end
            for (int g = 0; g < gap && b < NUM_BEATS-1; g++) begin
                tick();
            end
        end
    endtask

    task automatic sendPartial(input int beats);
        for (int b = 0; b < beats; b++) begin
            data_in  = beat_data[b];
            weights  = beat_weights[b];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic waitOutput(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkValue({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkValue({tag, "_ov_clear"}, out_valid, 0);
        checkValue({tag, "_ir_set"}, in_ready, 1);
    endtask

    task automatic runWindow(input string tag, input int gap);
        applyStimulus(gap, 1'b0);
        waitOutput(tag);
        checkOutput(tag);
        handshake(tag);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        act_mode  = 2'd0;
        bias      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        weights   = '0;
        #12;
        checkValue("reset_in_ready", in_ready, 1);
        checkValue("reset_out_valid", out_valid, 0);
        checkValue("reset_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic sum: 27 * 1.0 * 0.5 + 1.0 = 14.5 -> 7424, with latency check.
        setUniform(512, 256);
        setBias(512);
        act_mode = 2'd0;
        setExpected(7424);
        applyStimulus(0, 1'b0);
        checkValue("lat_fin_ov", out_valid, 0);
        checkValue("lat_fin_ir", in_ready, 0);
        tick();
        checkValue("lat_hold_ov", out_valid, 1);
        checkOutput("basic");

        // Backpressure: hold 5 cycles while an upstream beat is offered.
        data_in  = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkValue("bp_ov", out_valid, 1);
            checkValue("bp_ir", in_ready, 0);
            checkValue("bp_data", $signed(out_data[W-1:0]), 7424);
        end
        in_valid = 1'b0;
        handshake("bp");

        // Negative weights; bias/mode changed mid-window must be ignored.
        setUniform(512, -256);
        setBias(512);
        act_mode = 2'd0;
        setExpected(-6400);
        applyStimulus(0, 1'b1);
        waitOutput("neg_scramble");
        checkOutput("neg_scramble");
        handshake("neg_scramble");

        setBias(512);
        act_mode = 2'd1;
        setExpected(0);
        runWindow("relu", 0);

        setUniform(512, 256);
        act_mode = 2'd3;
        setExpected(3072);
        runWindow("relu6", 1);

        // Hard-swish driven purely by bias (zero weights).
        setUniform(512, 0);
        act_mode = 2'd2;
        setBias(512);   setExpected(340);  runWindow("hswish_p1", 0);
        setBias(2048);  setExpected(2040); runWindow("hswish_p4", 0);
        setBias(-2048); setExpected(0);    runWindow("hswish_m4", 0);
        setBias(-768);  setExpected(-192); runWindow("hswish_m1p5", 0);

        // Saturation at both rails.
        act_mode = 2'd0;
        setBias(0);
        setUniform(131071, 131071);
        setExpected(131071);
        runWindow("sat_pos", 0);
        setUniform(131071, -131072);
        setExpected(-131072);
        runWindow("sat_neg", 0);

        // Distinct per-channel/per-lane weights, varying data, gapped beats.
        // w(c,l) = (c-8)*64 + 8*l, beat b data = 512*(b+1), bias 0.5:
        // y(c) = 6*(576*(c-8) + 288) + 256 = 3456*(c-8) + 1984.
        for (int b = 0; b < NUM_BEATS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                beat_data[b][l*W +: W] = W'(512 * (b + 1));
            end
            for (int c = 0; c < NUM_CH; c++) begin
                for (int l = 0; l < LANES; l++) begin
                    beat_weights[b][(c*LANES+l)*W +: W] = W'((c - 8) * 64 + 8 * l);
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            expected[c] = W'(3456 * (c - 8) + 1984);
        end
        setBias(256);
        act_mode = 2'd0;
        runWindow("model", 2);

        // Flush after two beats; the beat offered with flush is dropped.
        setUniform(512, 256);
        setBias(512);
        sendPartial(2);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkValue("flush_ir", in_ready, 1);
        checkValue("flush_ov", out_valid, 0);
        setUniform(512, 128);
        setBias(0);
        setExpected(3456);
        runWindow("flush_fresh", 0);

        // Flush while holding a result: valid drops, data is kept.
        setUniform(512, 256);
        setBias(512);
        setExpected(7424);
        applyStimulus(0, 1'b0);
        waitOutput("hold_flush");
        checkOutput("hold_flush");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkValue("hold_flush_ov", out_valid, 0);
        checkValue("hold_flush_ir", in_ready, 1);
        checkValue("hold_flush_data", $signed(out_data[W-1:0]), 7424);

        // Asynchronous reset mid-window takes effect without a clock edge.
        sendPartial(2);
        #2;
        rst = 1'b1;
        #1;
        checkValue("arst_ov", out_valid, 0);
        checkValue("arst_ir", in_ready, 1);
        checkValue("arst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        setUniform(512, 128);
        setBias(0);
        act_mode = 2'd0;
        setExpected(3456);
        runWindow("post_rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
